div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port start, input, 1 bit: divide request from EX, held high until ready is seen.
REQ-005 SHALL have port signed_div, input, 1 bit: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 SHALL have port dividend, input, WIDTH bits: dividend; sampled with start.
REQ-007 SHALL have port divisor, input, WIDTH bits: divisor; sampled with start.
REQ-008 SHALL have port annul, input, 1 bit: flush of the requesting instruction.
REQ-009 SHALL have port stallreq_for_ex, output, 1 bit: stall request to CTRL while a divide is outstanding.
REQ-010 SHALL have port ready, output, 1 bit: result valid, one-cycle pulse.
REQ-011 SHALL have port quotient, output, WIDTH bits: quotient (LO).
REQ-012 SHALL have port remainder, output, WIDTH bits: remainder (HI).

Function
REQ-013 SHALL use FSM states IDLE, PREP, CALC, FIX and DONE.
REQ-014 SHALL, in IDLE with start=1 and annul=0, latch the operands and signed_div, then go to PREP.
REQ-015 SHALL, in PREP, form unsigned magnitudes (absolute value when signed), record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign), and clear the iteration counter.
REQ-016 SHALL, in PREP with divisor=0, go directly to DONE with quotient all-ones and remainder = original dividend.
REQ-017 SHALL, in PREP with nonzero divisor, go to CALC.
REQ-018 SHALL, in CALC, perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-019 SHALL, in FIX, two's-complement negate the quotient and/or remainder per the recorded signs (signed only), then go to DONE.
REQ-020 SHALL, in DONE, drive ready=1 for exactly one cycle, ignore start, and return to IDLE.
REQ-021 SHALL drive stallreq_for_ex = (IDLE and start and not annul) or PREP or CALC or FIX; it SHALL be 0 in DONE so the pipeline advances that cycle.
REQ-022 SHALL hold quotient and remainder stable from DONE until the next accepted start; they SHALL be undefined-free (registered) at all times.
REQ-023 SHALL give latency for nonzero divisor as: start cycle n, ready in cycle n+WIDTH+3, stallreq_for_ex high for cycles n..n+WIDTH+2.
REQ-024 SHALL give latency for divisor=0 as: ready in cycle n+2.
REQ-025 SHALL handle the signed overflow case (-2^(WIDTH-1) / -1) as quotient = 0x80000000 and remainder = 0 (WIDTH=32), with no special casing beyond the magnitude arithmetic.
REQ-026 SHALL, on annul=1 in any state, go to IDLE on the next edge with no ready pulse and leave the outputs unchanged; annul SHALL take priority over start.
REQ-027 SHALL, while annul=1, hold stallreq_for_ex at 0.
REQ-028 SHALL size the iteration counter as clog2(WIDTH)+1 bits with no wrap during CALC.

Reset
REQ-029 SHALL, while rst=0, asynchronously force state IDLE and stallreq_for_ex=0, ready=0, quotient=0, remainder=0 and the counter to 0.
REQ-030 SHALL, on rst deassertion mid-operation, discard the operation and begin the first cycle in IDLE.

Verification
REQ-031 SHALL cover: unsigned 100/7 -> quotient=14, remainder=2, ready in cycle n+35, stallreq_for_ex high cycles n..n+34.
REQ-032 SHALL cover: signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; unsigned 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
REQ-033 SHALL cover: divide by zero, dividend=0x1234 -> quotient=0xFFFFFFFF, remainder=0x1234, ready in cycle n+2.
REQ-034 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-035 SHALL cover: annul in cycle n+10 -> IDLE at n+11, stallreq_for_ex=0, no ready pulse; a new start at n+12 -> correct result in cycle n+47.
REQ-036 SHALL cover: rst=0 during CALC -> all outputs 0 immediately (asynchronously); after release, start 9/3 -> quotient=3, remainder=0.

Source files
------------

// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage and the iterative divider.
// master = EX-stage requester, slave = divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             stallreq_for_ex;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, dividend, divisor, annul,
        input  stallreq_for_ex, ready, quotient, remainder
    );

    modport slave (
        input  start, signed_div, dividend, divisor, annul,
        output stallreq_for_ex, ready, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) for the EX stage: one quotient bit per
// cycle on operand magnitudes, with sign fix-up afterwards.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvs_q;
    logic             signed_q;
    logic [WIDTH-1:0] quo_w_q, rem_w_q, mag_d_q;
    logic             qneg_q, rneg_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    logic             stall_d, ready_d;
    logic             last_step;
    logic [WIDTH:0]   trial, diff;
    logic             fits;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    // Partial remainder is always below the divisor, so trial fits in WIDTH+1 bits
    // and the borrow bit of diff tells whether the divisor goes in.
    assign trial     = {rem_w_q, quo_w_q[WIDTH-1]};
    assign diff      = trial - {1'b0, mag_d_q};
    assign fits      = ~diff[WIDTH];
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_d = 1'b0;
        ready_d = 1'b0;
        if (bus.annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = PREP;
                PREP:    state_d = (dvs_q == '0) ? DONE : CALC;
                CALC:    if (last_step) state_d = FIX;
                FIX:     state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // Stall drops in DONE so the pipeline consumes the result that cycle.
        if (rst && !bus.annul) begin
            stall_d = ((state_q == IDLE) && bus.start) ||
                      (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
            ready_d = (state_q == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q    <= '0;
            dvs_q    <= '0;
            signed_q <= 1'b0;
            quo_w_q  <= '0;
            rem_w_q  <= '0;
            mag_d_q  <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
        end else if (!bus.annul) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dvd_q    <= bus.dividend;
                        dvs_q    <= bus.divisor;
                        signed_q <= bus.signed_div;
                    end
                end
                PREP: begin
                    quo_w_q <= magnitude(dvd_q, signed_q);
                    rem_w_q <= '0;
                    mag_d_q <= magnitude(dvs_q, signed_q);
                    qneg_q  <= signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    rneg_q  <= signed_q & dvd_q[WIDTH-1];
                    cnt_q   <= '0;
                    if (dvs_q == '0) begin
                        quot_q <= '1;
                        rem_q  <= dvd_q;
                    end
                end
                CALC: begin
                    rem_w_q <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_w_q <= {quo_w_q[WIDTH-2:0], fits};
                    cnt_q   <= cnt_q + 1'b1;
                end
                FIX: begin
                    quot_q <= qneg_q ? (~quo_w_q + 1'b1) : quo_w_q;
                    rem_q  <= rneg_q ? (~rem_w_q + 1'b1) : rem_w_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.stallreq_for_ex = stall_d;
    assign bus.ready           = ready_d;
    assign bus.quotient        = quot_q;
    assign bus.remainder       = rem_q;
endmodule
